// File: rtl/eth_pkg.sv
// Shared types for the Ethernet receive slice: FSM states, FIFO entry layout,
// statistics counter type and small helpers.
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    DROP = 2'd2
  } rx_state_t;

  localparam int WORD_W    = 34;
  localparam int START_BIT = 32;
  localparam int END_BIT   = 33;

  typedef logic [15:0] cnt_t;

  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [WORD_W-1:0] mk_word(input logic e, input logic s,
                                                input logic [31:0] d);
    logic [WORD_W-1:0] w;
    w            = '0;
    w[31:0]      = d;
    w[START_BIT] = s;
    w[END_BIT]   = e;
    return w;
  endfunction

endpackage

// File: rtl/eth_rx_if.sv
// Port-side word stream plus ingress FIFO write port of one switch port.
//
// Stream: i_start marks the first word and i_end the last; every cycle from
// i_start through i_end carries a valid word and there is no backpressure.
// FIFO: wr_en is a one-cycle write strobe qualifying wr_data; fifo_free and
// full are status from the FIFO and are sampled, never handshaken.
interface eth_rx_if #(
  parameter int FIFO_AW = 6
) ();

  logic [31:0]              i_data;
  logic                     i_start;
  logic                     i_end;
  logic [FIFO_AW:0]         fifo_free;
  logic                     full;
  logic                     wr_en;
  logic [eth_pkg::WORD_W-1:0] wr_data;

  modport master (
    output i_data, i_start, i_end, fifo_free, full,
    input  wr_en, wr_data
  );

  modport slave (
    input  i_data, i_start, i_end, fifo_free, full,
    output wr_en, wr_data
  );

endinterface

// File: rtl/eth_addr_match.sv
// Combinational lookup of a destination address in the port table; reports a
// hit and the lowest matching port index.
module eth_addr_match #(
  parameter int          NUM_PORTS = 2,
  parameter int          PIDX_W    = 1,
  parameter logic [31:0] PORT_ADDR [NUM_PORTS] = '{default: 32'h0}
) (
  input  logic [31:0]       addr,
  output logic              hit,
  output logic [PIDX_W-1:0] idx
);

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (addr == PORT_ADDR[i]) begin
        hit = 1'b1;
        idx = PIDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/eth_rx.sv
// Ethernet receiver: admits whole packets into the ingress FIFO and terminates
// bad traffic cleanly. Statistics counters are built only with ETH_RX_STATS_EN.
module eth_rx
  import eth_pkg::*;
#(
  parameter int          NUM_PORTS     = 2,
  parameter logic [31:0] PORT_ADDR [NUM_PORTS] = '{default: 32'h0},
  parameter int          MAX_PKT_WORDS = 64,
  parameter int          FIFO_AW       = 6,
  parameter int          PIDX_W        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  eth_rx_if.slave           bus,
  output logic              o_rx_busy,
  output logic [PIDX_W-1:0] o_dest_port,
  output cnt_t              pkt_cnt,
  output cnt_t              drop_cnt,
  output cnt_t              err_cnt,
  output rx_state_t         dbg_state
);

  localparam int CNT_W = $clog2(MAX_PKT_WORDS + 1);

  rx_state_t         state;
  logic [CNT_W-1:0]  word_cnt;
  logic              hit;
  logic [PIDX_W-1:0] hit_idx;
  logic [31:0]       free_ext;
  logic              room;
  logic              at_max;

  eth_addr_match #(
    .NUM_PORTS (NUM_PORTS),
    .PIDX_W    (PIDX_W),
    .PORT_ADDR (PORT_ADDR)
  ) u_match (
    .addr (bus.i_data),
    .hit  (hit),
    .idx  (hit_idx)
  );

  // Admission needs space for a full maximum-size packet plus one entry.
  assign free_ext  = {{(31 - FIFO_AW){1'b0}}, bus.fifo_free};
  assign room      = free_ext >= (32'(MAX_PKT_WORDS) + 32'd1);
  assign at_max    = (word_cnt == CNT_W'(MAX_PKT_WORDS - 1));
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      bus.wr_en   <= 1'b0;
      bus.wr_data <= '0;
      o_rx_busy   <= 1'b0;
      o_dest_port <= '0;
      word_cnt    <= '0;
    end else begin
      bus.wr_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_start && !bus.i_end) begin
            if (hit && room) begin
              state       <= RX;
              o_rx_busy   <= 1'b1;
              o_dest_port <= hit_idx;
              word_cnt    <= CNT_W'(1);
              bus.wr_en   <= !bus.full;
              bus.wr_data <= mk_word(1'b0, 1'b1, bus.i_data);
            end else begin
              state <= DROP;
            end
          end
        end
        RX: begin
          bus.wr_en <= !bus.full;
          word_cnt  <= word_cnt + CNT_W'(1);
          if (bus.i_start) begin
            // A new start means the old packet lost its end: close it here.
            bus.wr_data <= mk_word(1'b1, 1'b0, bus.i_data);
            o_rx_busy   <= 1'b0;
            state       <= bus.i_end ? IDLE : DROP;
          end else begin
            bus.wr_data <= mk_word(bus.i_end || at_max, 1'b0, bus.i_data);
            if (bus.i_end) begin
              state     <= IDLE;
              o_rx_busy <= 1'b0;
            end else if (at_max) begin
              state     <= DROP;
              o_rx_busy <= 1'b0;
            end
          end
        end
        DROP: begin
          if (bus.i_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ETH_RX_STATS_EN
  logic pkt_inc;
  logic drop_inc;
  logic err_inc;

  always_comb begin
    pkt_inc  = 1'b0;
    drop_inc = 1'b0;
    err_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_start) begin
          if (bus.i_end || !hit || !room) drop_inc = 1'b1;
          else                            err_inc  = bus.full;
        end
      end
      RX: begin
        err_inc = bus.full || bus.i_start || (!bus.i_end && at_max);
        pkt_inc = bus.i_end && !bus.i_start;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (pkt_inc)  pkt_cnt  <= sat_inc(pkt_cnt);
      if (drop_inc) drop_cnt <= sat_inc(drop_cnt);
      if (err_inc)  err_cnt  <= sat_inc(err_cnt);
    end
  end
`else
  assign pkt_cnt  = '0;
  assign drop_cnt = '0;
  assign err_cnt  = '0;
`endif

endmodule
